// File: rtl/uart_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_deser                                                |
// | Description : UART receive deserializer, 8N1 (8E1 with UART_RX_PARITY_EN). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_line,
    output logic [7:0] o_rx,
    output logic       o_irq,
    output logic       o_rx_busy,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam int c_TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_TMR_W-1:0] c_TMR_FULL = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_HALF = c_TMR_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_ERR    = 3'd5;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [c_TMR_W-1:0]     r_tmr;
    logic                   w_tmr_full;
    logic                   w_tmr_half;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shreg;
    logic [7:0]             r_rx;
    logic                   r_irq;

    // Preset to idle-high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_line};
        end
    end

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_tmr_full = (r_tmr == c_TMR_FULL);
    assign w_tmr_half = (r_tmr == c_TMR_HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_rx_s) w_state_nxt = c_ST_START;
            end
            c_ST_START: begin
                if (w_tmr_half) w_state_nxt = w_rx_s ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_tmr_full && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = c_ST_PARITY;
`else
                    w_state_nxt = c_ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_ST_PARITY: begin
                if (w_tmr_full) w_state_nxt = c_ST_STOP;
            end
`endif
            c_ST_STOP: begin
                if (w_tmr_full) w_state_nxt = w_rx_s ? c_ST_IDLE : c_ST_ERR;
            end
            c_ST_ERR: begin
                if (w_rx_s) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_rx_busy   = 1'b0;
        o_frame_err = 1'b0;
        if (r_state != c_ST_IDLE) o_rx_busy = 1'b1;
        if (r_state == c_ST_ERR)  o_frame_err = 1'b1;
    end

    // Timer restarts on every state change so each mark is one bit after the previous
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == c_ST_IDLE) ||
                     (r_state == c_ST_ERR) || w_tmr_full) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
            r_rx      <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (r_state == c_ST_START) begin
                r_bit_idx <= 3'd0;
            end
            if ((r_state == c_ST_DATA) && w_tmr_full) begin
                r_shreg[r_bit_idx] <= w_rx_s;
                r_bit_idx          <= r_bit_idx + 1'b1;
            end
            if ((r_state == c_ST_STOP) && w_tmr_full && w_rx_s) begin
                r_rx  <= r_shreg;
                r_irq <= 1'b1;
            end
        end
    end

    assign o_rx  = r_rx;
    assign o_irq = r_irq;

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && (w_state_nxt == c_ST_START)) begin
            r_parity_err <= 1'b0;
        end else if ((r_state == c_ST_PARITY) && w_tmr_full) begin
            r_parity_err <= (w_rx_s != ^r_shreg);
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_deser                                             |
// | Description : Self-checking bench for uart_rx_deser, randomized frames.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_deser;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] o_rx;
    logic       o_irq;
    logic       o_rx_busy;
    logic       o_frame_err;
    logic       o_parity_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] last_good = 8'h00;
    bit         busy_seen = 1'b0;
    int         irq_bad = 0;
    logic       prev_irq = 1'b0;
    logic       prev_busy = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_deser #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx_line    (rx_line),
        .o_rx         (o_rx),
        .o_irq        (o_irq),
        .o_rx_busy    (o_rx_busy),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err)
    );

    // Capture every strobe; a strobe must be single-cycle, with busy low now and high just before
    always @(negedge clk) begin
        if (o_irq) begin
            obs_q.push_back(o_rx);
            if (prev_irq || o_rx_busy || !prev_busy) irq_bad++;
        end
        if (o_rx_busy) busy_seen = 1'b1;
        prev_irq  = o_irq;
        prev_busy = o_rx_busy;
    end

    task automatic drive_bit(input logic b, input int len);
        rx_line = b;
        repeat (len) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_len);
        drive_bit(1'b0, C);
        for (int i = 0; i < 8; i++) drive_bit(d[i], C);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip, C);
`endif
        drive_bit(1'b1, stop_len);
        exp_q.push_back(d);
        last_good = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_rx !== 8'h00) begin failures++; $display("FAIL reset_rx got=%h exp=00", o_rx); end
        checks++; if (o_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", o_irq); end
        checks++; if (o_rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_rx_busy); end
        checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", o_frame_err); end
        checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", o_parity_err); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (o_rx_busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", o_rx_busy); end
        last_good = 8'h00;
    endtask

    task automatic test_single();
        obs_q.delete();
        exp_q.delete();
        send_frame(8'hA5, C);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", obs_q.size()); end
        checks++; if (obs_q[0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", obs_q[0]); end
        checks++; if (o_rx !== 8'hA5) begin failures++; $display("FAIL single_hold got=%h exp=a5", o_rx); end
        checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL single_ferr got=%b exp=0", o_frame_err); end
        checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL single_perr got=%b exp=0", o_parity_err); end
        checks++; if (o_rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", o_rx_busy); end
    endtask

    task automatic test_back_to_back();
        obs_q.delete();
        exp_q.delete();
        send_frame(8'h3C, C);
        send_frame(8'hC3, C);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", obs_q.size()); end
        checks++; if (obs_q[0] !== 8'h3C) begin failures++; $display("FAIL b2b_first got=%h exp=3c", obs_q[0]); end
        checks++; if (obs_q[1] !== 8'hC3) begin failures++; $display("FAIL b2b_second got=%h exp=c3", obs_q[1]); end
    endtask

    // Random bytes with random idle gaps, some with a stop bit cut to just past its middle
    task automatic test_random();
        obs_q.delete();
        exp_q.delete();
        for (int f = 0; f < 10; f++) begin
            logic [7:0] d;
            int stop_len;
            d = 8'($urandom);
            stop_len = ($urandom_range(0, 1) == 1) ? (C / 2 + 4) : C;
            send_frame(d, stop_len);
            if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 12));
        end
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_data[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int n;
        n = obs_q.size();
        repeat (4) @(negedge clk);
        busy_seen = 1'b0;
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 3 * C);
        checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_pulse got=%b exp=1", busy_seen); end
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL glitch_irq got=%0d exp=%0d", obs_q.size(), n); end
        checks++; if (o_rx !== last_good) begin failures++; $display("FAIL glitch_rx got=%h exp=%h", o_rx, last_good); end
        checks++; if (o_rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", o_rx_busy); end
    endtask

    task automatic test_frame_err();
        int n;
        int bad;
        logic [7:0] d;
        n = obs_q.size();
        d = 8'h55;
        drive_bit(1'b0, C);
        for (int i = 0; i < 8; i++) drive_bit(d[i], C);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d, C);
`endif
        drive_bit(1'b0, C / 2 + 6);
        bad = 0;
        for (int i = 0; i < C + 40 - (C / 2 + 6); i++) begin
            @(negedge clk);
            if (!(o_frame_err === 1'b1 && o_rx_busy === 1'b1)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL ferr_overlap bad_cycles=%0d exp=0", bad); end
        drive_bit(1'b1, 6);
        checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", o_frame_err); end
        checks++; if (o_rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_clear got=%b exp=0", o_rx_busy); end
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL ferr_irq got=%0d exp=%0d", obs_q.size(), n); end
        checks++; if (o_rx !== last_good) begin failures++; $display("FAIL ferr_rx got=%h exp=%h", o_rx, last_good); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] d;
        d = 8'h6B;
        drive_bit(1'b0, C);
        for (int i = 0; i < 4; i++) drive_bit(d[i], C);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_rx !== 8'h00) begin failures++; $display("FAIL rstmid_rx got=%h exp=00", o_rx); end
        checks++; if (o_irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", o_irq); end
        checks++; if (o_rx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", o_rx_busy); end
        checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%b exp=0", o_frame_err); end
        checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL rstmid_perr got=%b exp=0", o_parity_err); end
        rx_line = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = obs_q.size();
        repeat (2 * C) @(negedge clk);
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL rstmid_no_strobe got=%0d exp=%0d", obs_q.size(), n); end
        send_frame(8'h81, C);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() != n + 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", obs_q.size(), n + 1); end
        checks++; if (obs_q[n] !== 8'h81) begin failures++; $display("FAIL rstmid_data got=%h exp=81", obs_q[n]); end
        checks++; if (o_rx !== 8'h81) begin failures++; $display("FAIL rstmid_hold got=%h exp=81", o_rx); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int n;
        n = obs_q.size();
        par_flip = 1'b1;
        send_frame(8'h07, C);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() != n + 1) begin failures++; $display("FAIL par_bad_irq got=%0d exp=%0d", obs_q.size(), n + 1); end
        checks++; if (o_rx !== 8'h07) begin failures++; $display("FAIL par_bad_rx got=%h exp=07", o_rx); end
        checks++; if (o_parity_err !== 1'b1) begin failures++; $display("FAIL par_bad_flag got=%b exp=1", o_parity_err); end
        par_flip = 1'b0;
        send_frame(8'h07, C);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() != n + 2) begin failures++; $display("FAIL par_good_irq got=%0d exp=%0d", obs_q.size(), n + 2); end
        checks++; if (o_parity_err !== 1'b0) begin failures++; $display("FAIL par_good_flag got=%b exp=0", o_parity_err); end
    endtask
`endif

    task automatic test_strobe_shape();
        checks++;
        if (irq_bad != 0) begin
            failures++;
            $display("FAIL irq_shape bad_strobes=%0d exp=0", irq_bad);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_strobe_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
